// File: rtl/axis_generator.sv
// axis_generator: AXI4-Stream master emitting an incrementing counter pattern
// framed into packets of PACKET_LEN beats (tlast on the final beat).
// Optional feature: define AXIS_GEN_PKT_CNT_EN to add m00_axis_pkt_count,
// a 32-bit count of accepted tlast beats.
module axis_generator #(
  parameter int unsigned          DATA_SIZE   = 32,
  parameter int unsigned          PACKET_LEN  = 8,
  parameter logic [DATA_SIZE-1:0] START_VALUE = '0
) (
  input  logic                   m00_axis_aclk,
  input  logic                   m00_axis_aresetn,
  input  logic                   m00_axis_enable,
  output logic [DATA_SIZE-1:0]   m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
  output logic                   m00_axis_tvalid,
  input  logic                   m00_axis_tready,
  output logic                   m00_axis_tlast
`ifdef AXIS_GEN_PKT_CNT_EN
  ,
  output logic [31:0]            m00_axis_pkt_count
`endif
);

  localparam int unsigned STRB_W = DATA_SIZE / 8;
  localparam int unsigned BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PACKET_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [DATA_SIZE-1:0]  data, data_next;
  logic [BEAT_W-1:0]     beat, beat_next;
  logic                  tlast_q, tlast_next;
  logic                  handshake;

  // Next-state, counter and framing logic; tlast is precomputed for the next beat
  always_comb begin
    state_next = state;
    data_next  = data;
    beat_next  = beat;
    tlast_next = 1'b0;
    handshake  = (state == VALID) && m00_axis_tready;

    case (state)
      IDLE:    if (m00_axis_enable) state_next = VALID;
      VALID:   if (handshake && !m00_axis_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (handshake) begin
      data_next = data + DATA_SIZE'(1);
      beat_next = (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
    end

    tlast_next = (state_next == VALID) && (beat_next == LAST_BEAT);
  end

  // State, counters and registered tlast
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state   <= IDLE;
      data    <= START_VALUE;
      beat    <= '0;
      tlast_q <= 1'b0;
    end else begin
      state   <= state_next;
      data    <= data_next;
      beat    <= beat_next;
      tlast_q <= tlast_next;
    end
  end

`ifdef AXIS_GEN_PKT_CNT_EN
  logic [31:0] pkt_cnt;

  // Count accepted end-of-packet beats
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      pkt_cnt <= '0;
    end else if (handshake && tlast_q) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  assign m00_axis_pkt_count = pkt_cnt;
`endif

  assign m00_axis_tvalid = (state == VALID);
  assign m00_axis_tdata  = data;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = {STRB_W{1'b1}};

endmodule

// File: tb/tb_axis_generator.sv
// Bench for axis_generator: scoreboard of expected beats, monitor pops on handshake.
module tb_axis_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid, tlast;

  logic        w_enable, w_tready;
  logic [7:0]  w_tdata;
  logic [0:0]  w_tstrb;
  logic        w_tvalid, w_tlast;

  int compared = 0;
  int mism     = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  logic [31:0] model_data;
  int          model_beat;

  always #5 clk = ~clk;

  axis_generator #(.DATA_SIZE(32), .PACKET_LEN(8), .START_VALUE(32'd0)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .m00_axis_enable  (enable),
    .m00_axis_tdata   (tdata),
    .m00_axis_tstrb   (tstrb),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tready  (tready),
    .m00_axis_tlast   (tlast)
`ifdef AXIS_GEN_PKT_CNT_EN
    ,
    .m00_axis_pkt_count ()
`endif
  );

  axis_generator #(.DATA_SIZE(8), .PACKET_LEN(3), .START_VALUE(8'hFE)) u_wrap (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .m00_axis_enable  (w_enable),
    .m00_axis_tdata   (w_tdata),
    .m00_axis_tstrb   (w_tstrb),
    .m00_axis_tvalid  (w_tvalid),
    .m00_axis_tready  (w_tready),
    .m00_axis_tlast   (w_tlast)
`ifdef AXIS_GEN_PKT_CNT_EN
    ,
    .m00_axis_pkt_count ()
`endif
  );

`ifdef AXIS_GEN_PKT_CNT_EN
  logic        p_enable, p_tready;
  logic [31:0] p_tdata;
  logic [3:0]  p_tstrb;
  logic        p_tvalid, p_tlast;
  logic [31:0] p_count;

  axis_generator #(.DATA_SIZE(32), .PACKET_LEN(4), .START_VALUE(32'd0)) u_pkt (
    .m00_axis_aclk      (clk),
    .m00_axis_aresetn   (rst_n),
    .m00_axis_enable    (p_enable),
    .m00_axis_tdata     (p_tdata),
    .m00_axis_tstrb     (p_tstrb),
    .m00_axis_tvalid    (p_tvalid),
    .m00_axis_tready    (p_tready),
    .m00_axis_tlast     (p_tlast),
    .m00_axis_pkt_count (p_count)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mism++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_data = 32'd0;
    model_beat = 0;
  endtask

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: model_data, last: (model_beat == 7)});
      model_data = model_data + 32'd1;
      model_beat = (model_beat == 7) ? 0 : model_beat + 1;
    end
  endtask

  // Advance on posedge+1 until the scoreboard holds at most k beats
  task automatic wait_q(input int k);
    int cyc = 0;
    while (exp_q.size() > k && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() > k) begin
      compared++;
      mism++;
      $error("FAIL wait_q timeout: observed=%0d pending expected=%0d", exp_q.size(), k);
    end
  endtask

  // Stream n beats, dropping enable during the last one so the FSM returns to idle
  task automatic stream(input int n);
    push_beats(n);
    enable = 1'b1;
    tready = 1'b1;
    wait_q(1);
    enable = 1'b0;
    wait_q(0);
    check("idle_after_last", 32'(tvalid), 32'd0);
  endtask

  // Monitor: every presented beat must match the scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (rst_n && tvalid) begin
      if (exp_q.size() != 0) begin
        check("tdata", tdata, exp_q[0].data);
        check("tlast", 32'(tlast), 32'(exp_q[0].last));
        if (tready) void'(exp_q.pop_front());
      end else if (tready) begin
        compared++;
        mism++;
        $error("FAIL extra_beat: observed tdata=%0h expected no handshake", tdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wexp [4];
    wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00; wexp[3] = 8'h01;

    rst_n = 1'b0; enable = 1'b0; tready = 1'b0;
    w_enable = 1'b0; w_tready = 1'b0;
`ifdef AXIS_GEN_PKT_CNT_EN
    p_enable = 1'b0; p_tready = 1'b0;
`endif
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_tstrb", 32'(tstrb), 32'hF);
    check("rst_w_tdata", 32'(w_tdata), 32'hFE);
`ifdef AXIS_GEN_PKT_CNT_EN
    check("rst_pkt_count", p_count, 32'd0);
`endif
    rst_n = 1'b1;

    // Continuous stream 0..9, tlast on 7
    @(posedge clk); #1;
    stream(10);

    // Async reset between edges while a beat is stalled
    enable = 1'b1; tready = 1'b0;
    @(posedge clk); #2;
    check("pre_rst_tvalid", 32'(tvalid), 32'd1);
    check("pre_rst_tdata", tdata, 32'd10);
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(tvalid), 32'd0);
    check("async_rst_tdata", tdata, 32'd0);
    check("async_rst_tlast", 32'(tlast), 32'd0);
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Enable toggling: 5 beats, 5 idle cycles, then resume at 5 (tlast on 7)
    stream(5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("gap_tvalid", 32'(tvalid), 32'd0);
    end
    stream(5);

    // Backpressure with enable and tready falling together while tdata=3
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    push_beats(6);
    enable = 1'b1; tready = 1'b1;
    wait_q(3);
    enable = 1'b0; tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_tvalid", 32'(tvalid), 32'd1);
      check("stall_tdata", tdata, 32'd3);
    end
    enable = 1'b1; tready = 1'b1;
    wait_q(1);
    enable = 1'b0;
    wait_q(0);
    check("idle_after_stall", 32'(tvalid), 32'd0);

    // Wrap: 8-bit counter from FE, PACKET_LEN=3
    w_enable = 1'b1; w_tready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wrap_tvalid", 32'(w_tvalid), 32'd1);
      check("wrap_tdata", 32'(w_tdata), 32'(wexp[i]));
      check("wrap_tlast", 32'(w_tlast), (i == 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    w_enable = 1'b0; w_tready = 1'b0;

`ifdef AXIS_GEN_PKT_CNT_EN
    // Packet counter: 12 beats of 4-beat packets
    p_enable = 1'b1; p_tready = 1'b1;
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    p_enable = 1'b0; p_tready = 1'b0;
    check("pkt_count", p_count, 32'd3);
    check("pkt_tdata", p_tdata, 32'd12);
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/axis_generator.md
# axis_generator

AXI4-Stream master that emits an incrementing counter data pattern with periodic packet framing. It is a traffic source for exercising downstream stream sinks, FIFOs and processing blocks. Output is gated by an enable input and obeys the AXI4-Stream valid/ready handshake.

## Interface
Parameters:
- DATA_SIZE, 32: tdata width in bits; multiple of 8, minimum 8.
- PACKET_LEN, 8: beats per packet; tlast marks the final beat; minimum 1.
- START_VALUE, 0: first tdata value after reset.

Ports:
- m00_axis_aclk  in  1  clock; all logic on rising edge.
- m00_axis_aresetn  in  1  reset, asynchronous, active-low.
- m00_axis_enable  in  1  request to stream; sampled each rising edge.
- m00_axis_tdata  out  DATA_SIZE  beat data.
- m00_axis_tstrb  out  DATA_SIZE/8  byte qualifiers; constant all ones.
- m00_axis_tvalid  out  1  beat valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  last beat of packet.

## Operation
- Handshake (beat accepted) = tvalid && tready at a rising edge.
- Two-state FSM:
  - IDLE: tvalid=0. Go to VALID when enable=1.
  - VALID: tvalid=1. On handshake with enable=0, go to IDLE. Otherwise stay.
- Once asserted, tvalid is never withdrawn before a handshake, even if enable drops. tdata and tlast stay stable while tvalid=1 and tready=0.
- Data counter:
  - Reset value START_VALUE.
  - Increments by 1 on each handshake only.
  - Wraps modulo 2^DATA_SIZE.
  - Retains its value across enable off/on.
- Beat index:
  - Counts 0..PACKET_LEN-1 and increments on handshake.
  - Wraps to 0 after the beat with index PACKET_LEN-1.
  - Retains its value across enable toggles, so packets are never truncated by enable.
- tlast = 1 exactly when tvalid=1 and beat index = PACKET_LEN-1. With PACKET_LEN=1, every beat has tlast.
- tstrb is always {DATA_SIZE/8{1'b1}}.

## Timing
- Reset is asynchronous and takes effect immediately. While reset is asserted: tvalid=0, tlast=0, tdata=START_VALUE, beat index=0, FSM=IDLE, tstrb=all ones.
- Reset asserted mid-stream aborts the current beat. After release, streaming restarts from START_VALUE with beat index 0.
- Latency: if enable=1 at rising edge N, tvalid=1 after edge N, so the first handshake can occur at edge N+1.
- Back-to-back throughput: with enable=1 and tready=1 continuously, one beat is accepted per clock. tdata advances every cycle with no bubbles.
- tready=0 with tvalid=1 stalls: no counter or index change.
- If enable and tready both fall at the same edge while tvalid=1, no handshake occurs at that edge. tvalid stays 1 with the same data until tready returns.
- If enable=0 and tready=1 at an edge while tvalid=1, that beat completes and tvalid=0 after that edge.
- All outputs are registered; there is no combinational path from tready or enable to any output.

## Configuration
- AXIS_GEN_PKT_CNT_EN defined:
  - Adds output port m00_axis_pkt_count, 32 bits.
  - It counts handshakes where tlast=1.
  - Reset value 0; wraps modulo 2^32.
- AXIS_GEN_PKT_CNT_EN undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold aresetn=0 for 2 cycles with enable=0 -> tvalid=0, tlast=0, tdata=0, tstrb=4'hF. Asserting reset asynchronously between edges clears tvalid immediately.
- Continuous stream, DATA_SIZE=32, PACKET_LEN=8, enable=tready=1 for 10 cycles:
  - Accepted tdata = 0,1,...,9.
  - tlast=1 only on the beat with tdata=7.
- Enable toggling: 5 beats, then enable=tready=0 for 5 cycles, then re-enable -> next accepted tdata=5 (no gap, no repeat). The beat with tdata=7 still carries tlast.
- Backpressure: tready=0 for 3 cycles while tvalid=1, tdata=3 -> tdata remains 3 and tvalid remains 1. The next handshake delivers 3, then 4.
- Wrap: DATA_SIZE=8, START_VALUE=8'hFE -> accepted tdata = FE, FF, 00, 01.
- With AXIS_GEN_PKT_CNT_EN defined, PACKET_LEN=4, 12 continuous beats -> pkt_count=3.
